// File: rtl/win_buzzer_ctrl.sv
// Round-end detector: confirms a mode-selected board win over several cycles,
// then drives a timed, acknowledgeable buzzer pulse and a saturating win counter.
module win_buzzer_ctrl #(
    parameter int NUM_CELLS      = 32,
    parameter int CONFIRM_CYCLES = 4,
    parameter int BUZZ_CYCLES    = 1000,
    parameter int COUNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic [1:0]           mode,
    input  logic [NUM_CELLS-1:0] screen_values,
    input  logic [NUM_CELLS-1:0] target,
    input  logic                 ack,
    output logic                 win,
    output logic                 buzz,
    output logic                 armed,
    output logic [COUNT_W-1:0]   win_count
);

    localparam int CONF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam int BUZZ_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WIN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [CONF_W-1:0]   conf_q, conf_d;
    logic [BUZZ_W-1:0]   timer_q, timer_d;
    logic                win_d, buzz_d, armed_d;
    logic [COUNT_W-1:0]  count_d;
    logic                match;

    // Win condition uses the mode captured at arm, never the live mode input.
    always_comb begin
        match = 1'b0;
        case (mode_q)
            2'b00:   match = (screen_values == '0);
            2'b01:   match = (screen_values == '1);
            2'b10:   match = (screen_values == target);
            default: match = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        conf_d  = conf_q;
        timer_d = timer_q;
        win_d   = win;
        buzz_d  = buzz;
        count_d = win_count;

        if (arm) begin
            state_d = ARMED;
            mode_d  = mode;
            conf_d  = '0;
            timer_d = '0;
            win_d   = 1'b0;
            buzz_d  = 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (!match) begin
                        conf_d = '0;
                    end else if (conf_q == CONF_LAST) begin
                        state_d = WIN;
                        win_d   = 1'b1;
                        buzz_d  = 1'b1;
                        conf_d  = '0;
                        timer_d = '0;
                        if (win_count != '1) begin
                            count_d = win_count + 1'b1;
                        end
                    end else begin
                        conf_d = conf_q + 1'b1;
                    end
                end
                // Ack and timer expiry share one exit so they cannot double-fire.
                WIN: begin
                    if (ack || (timer_q == BUZZ_LAST)) begin
                        state_d = DONE;
                        buzz_d  = 1'b0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode_q    <= 2'b00;
            conf_q    <= '0;
            timer_q   <= '0;
            win       <= 1'b0;
            buzz      <= 1'b0;
            armed     <= 1'b0;
            win_count <= '0;
        end else begin
            state     <= state_d;
            mode_q    <= mode_d;
            conf_q    <= conf_d;
            timer_q   <= timer_d;
            win       <= win_d;
            buzz      <= buzz_d;
            armed     <= armed_d;
            win_count <= count_d;
        end
    end

endmodule

// File: tb/tb_win_buzzer_ctrl.sv
// Self-checking bench for win_buzzer_ctrl: directed scenarios plus randomized
// traffic compared against a round-level behavioural model.
module tb_win_buzzer_ctrl;

    localparam int NC    = 8;
    localparam int CONF  = 3;
    localparam int BUZZ  = 5;
    localparam int CW    = 2;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          arm = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [NC-1:0] screen_values = '0;
    logic [NC-1:0] target = '0;
    logic          ack = 1'b0;
    logic          win, buzz, armed;
    logic [CW-1:0] win_count;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: round in progress, match streak, buzzer cycles left, rounds won.
    bit       m_running;
    bit [1:0] m_mode;
    int       m_streak;
    bit       m_win;
    int       m_buzz_left;
    int       m_count;

    win_buzzer_ctrl #(
        .NUM_CELLS(NC), .CONFIRM_CYCLES(CONF), .BUZZ_CYCLES(BUZZ), .COUNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .mode(mode),
        .screen_values(screen_values), .target(target), .ack(ack),
        .win(win), .buzz(buzz), .armed(armed), .win_count(win_count)
    );

    always #5 clk = ~clk;

    function automatic bit model_match(input bit [1:0] md, input bit [NC-1:0] sv, input bit [NC-1:0] tg);
        int ones;
        ones = $countones(sv);
        if (md == 2'd0) return ones == 0;
        if (md == 2'd1) return ones == NC;
        if (md == 2'd2) return sv == tg;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_running = 0; m_mode = 0; m_streak = 0;
        m_win = 0; m_buzz_left = 0; m_count = 0;
    endtask

    task automatic model_update();
        if (arm) begin
            m_running = 1; m_mode = mode; m_streak = 0; m_win = 0; m_buzz_left = 0;
        end else if (m_running) begin
            if (model_match(m_mode, screen_values, target)) begin
                m_streak++;
                if (m_streak == CONF) begin
                    m_running = 0; m_win = 1; m_buzz_left = BUZZ; m_streak = 0;
                    m_count = (m_count == MAXC) ? MAXC : m_count + 1;
                end
            end else begin
                m_streak = 0;
            end
        end else if (m_buzz_left > 0) begin
            m_buzz_left = ack ? 0 : m_buzz_left - 1;
        end
    endtask

    task automatic tick(input logic a, input logic [1:0] md, input logic [NC-1:0] sv,
                        input logic [NC-1:0] tg, input logic ak);
        arm = a; mode = md; screen_values = sv; target = tg; ack = ak;
        @(posedge clk);
        model_update();
        #1;
        arm = 1'b0; ack = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #7;
        n_cmp++; if (win !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_win got=%b exp=0", win); end
        n_cmp++; if (buzz !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_buzz got=%b exp=0", buzz); end
        n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_armed got=%b exp=0", armed); end
        n_cmp++; if (win_count !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_count got=%0d exp=0", win_count); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_clear();
        int high;
        tick(1, 2'b00, 8'h00, 8'h00, 0);
        for (int i = 1; i <= CONF; i++) begin
            tick(0, 2'b00, 8'h00, 8'h00, 0);
            n_cmp++;
            if (win !== (i == CONF)) begin n_fail++; $display("[TB] FAIL clear_win_edge%0d got=%b exp=%b", i, win, (i == CONF)); end
        end
        n_cmp++; if (buzz !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_buzz_on got=%b exp=1", buzz); end
        n_cmp++; if (win_count !== 2'd1) begin n_fail++; $display("[TB] FAIL clear_count got=%0d exp=1", win_count); end
        high = 1;
        for (int i = 0; i < 10; i++) begin
            tick(0, 2'b00, 8'h00, 8'h00, 0);
            if (buzz === 1'b1) high++;
        end
        n_cmp++; if (high != BUZZ) begin n_fail++; $display("[TB] FAIL clear_buzz_len got=%0d exp=%0d", high, BUZZ); end
        n_cmp++; if (win !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_win_hold got=%b exp=1", win); end
    endtask

    task automatic test_glitch();
        logic [NC-1:0] seq [6];
        bit exp_win [6];
        seq = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        exp_win = '{0, 0, 0, 0, 0, 1};
        tick(1, 2'b00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 2'b00, seq[i], 8'h00, 0);
            n_cmp++;
            if (win !== exp_win[i] || win !== m_win) begin
                n_fail++; $display("[TB] FAIL glitch_win_step%0d got=%b exp=%b", i, win, exp_win[i]);
            end
        end
        tick(0, 2'b00, 8'h00, 8'h00, 1);
    endtask

    task automatic test_target_reserved();
        tick(1, 2'b10, 8'hA5, 8'hA5, 0);
        for (int i = 0; i < CONF; i++) tick(0, 2'b11, 8'hA5, 8'hA5, 0);
        n_cmp++; if (win !== 1'b1) begin n_fail++; $display("[TB] FAIL target_win got=%b exp=1", win); end
        tick(1, 2'b11, 8'h00, 8'hA5, 0);
        for (int i = 0; i < 20; i++) tick(0, 2'b00, 8'h00, 8'h00, 0);
        n_cmp++; if (win !== 1'b0) begin n_fail++; $display("[TB] FAIL reserved_win got=%b exp=0", win); end
        n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("[TB] FAIL reserved_armed got=%b exp=1", armed); end
    endtask

    task automatic win_round();
        tick(1, 2'b01, 8'hFF, 8'h00, 0);
        for (int i = 0; i < CONF; i++) tick(0, 2'b01, 8'hFF, 8'h00, 0);
    endtask

    task automatic test_ack_rearm();
        win_round();
        tick(0, 2'b01, 8'hFF, 8'h00, 0);
        tick(0, 2'b01, 8'hFF, 8'h00, 1);
        n_cmp++; if (buzz !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_buzz got=%b exp=0", buzz); end
        n_cmp++; if (win !== 1'b1 || armed !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_done win=%b armed=%b exp win=1 armed=0", win, armed); end
        tick(0, 2'b01, 8'hFF, 8'h00, 1);
        n_cmp++; if (win !== 1'b1 || buzz !== 1'b0) begin n_fail++; $display("[TB] FAIL done_ack_ignored win=%b buzz=%b exp 1/0", win, buzz); end
        win_round();
        tick(0, 2'b01, 8'hFF, 8'h00, 0);
        tick(1, 2'b01, 8'h00, 8'h00, 0);
        n_cmp++; if (win !== 1'b0 || buzz !== 1'b0 || armed !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rearm_buzz win=%b buzz=%b armed=%b exp 0/0/1", win, buzz, armed);
        end
        for (int i = 0; i < CONF; i++) tick(0, 2'b01, 8'hFF, 8'h00, 0);
        tick(1, 2'b01, 8'hFF, 8'h00, 1);
        n_cmp++; if (armed !== 1'b1 || win !== 1'b0 || buzz !== 1'b0) begin
            n_fail++; $display("[TB] FAIL arm_ack_same armed=%b win=%b buzz=%b exp 1/0/0", armed, win, buzz);
        end
    endtask

    task automatic test_saturation_reset();
        int exp_cnt [4];
        exp_cnt = '{1, 2, 3, 3};
        pulse_reset();
        for (int r = 0; r < 4; r++) begin
            win_round();
            n_cmp++;
            if (win_count !== exp_cnt[r] || win_count !== m_count) begin
                n_fail++; $display("[TB] FAIL sat_count_round%0d got=%0d exp=%0d", r, win_count, exp_cnt[r]);
            end
            if (r < 3) tick(0, 2'b01, 8'hFF, 8'h00, 1);
        end
        tick(0, 2'b01, 8'hFF, 8'h00, 0);
        reset = 1'b0;
        #1;
        n_cmp++; if (buzz !== 1'b0 || win !== 1'b0 || win_count !== 2'd0) begin
            n_fail++; $display("[TB] FAIL async_reset buzz=%b win=%b count=%0d exp 0/0/0", buzz, win, win_count);
        end
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [NC-1:0] tg, sv;
        logic [1:0] md;
        tg = NC'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 30) == 0) tg = NC'($urandom);
            md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 8)
                sv = (m_mode == 2'd0) ? 8'h00 : (m_mode == 2'd1) ? 8'hFF : tg;
            else
                sv = NC'($urandom);
            tick($urandom_range(0, 11) == 0, md, sv, tg, $urandom_range(0, 7) == 0);
            n_cmp++; if (win !== m_win) begin n_fail++; $display("[TB] FAIL rand_win cyc%0d got=%b exp=%b", i, win, m_win); end
            n_cmp++; if (buzz !== (m_buzz_left > 0)) begin n_fail++; $display("[TB] FAIL rand_buzz cyc%0d got=%b exp=%b", i, buzz, (m_buzz_left > 0)); end
            n_cmp++; if (armed !== m_running) begin n_fail++; $display("[TB] FAIL rand_armed cyc%0d got=%b exp=%b", i, armed, m_running); end
            n_cmp++; if (win_count !== m_count) begin n_fail++; $display("[TB] FAIL rand_count cyc%0d got=%0d exp=%0d", i, win_count, m_count); end
        end
    endtask

    initial begin
        test_reset();
        test_all_clear();
        test_glitch();
        test_target_reserved();
        test_ack_rearm();
        test_saturation_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
